// File: rtl/activation_pkg.sv
// Shared types and constants for the activation stage.
//   act_mode_t : per-beat activation function select
//   STATS_W    : width of the optional saturation counter
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/activation_if.sv
// Stream interface for the activation stage.
//   slave  : the activation block (accepts input beats, produces output beats)
//   master : the surrounding datapath / testbench
// Signals:
//   activation_ready_in  block can accept a beat
//   activation_valid_in  upstream beat valid
//   activation_data_in   packed lanes, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   activation_mode_in   act_mode_t, travels with the beat
//   activation_ready_out downstream ready
//   activation_valid_out output beat valid
//   activation_data_out  activated lanes, same packing
interface activation_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CHANNELS   = 1
);
    import activation_pkg::*;

    logic                           activation_ready_in;
    logic                           activation_valid_in;
    logic [CHANNELS*DATA_WIDTH-1:0] activation_data_in;
    act_mode_t                      activation_mode_in;
    logic                           activation_ready_out;
    logic                           activation_valid_out;
    logic [CHANNELS*DATA_WIDTH-1:0] activation_data_out;

    modport master (
        input  activation_ready_in,
        output activation_valid_in,
        output activation_data_in,
        output activation_mode_in,
        output activation_ready_out,
        input  activation_valid_out,
        input  activation_data_out
    );

    modport slave (
        output activation_ready_in,
        input  activation_valid_in,
        input  activation_data_in,
        input  activation_mode_in,
        input  activation_ready_out,
        output activation_valid_out,
        output activation_data_out
    );

endinterface

// File: rtl/activation_lane.sv
// Single-lane activation datapath, purely combinational.
// Front half (x -> neg/shr/over) feeds the S1 registers; back half selects the
// final value from the registered S1 terms and feeds the S2 register.
// Ports:
//   x                         raw lane input
//   neg, shr, over            sign, arithmetic-shifted value, x > CLIP_MAX
//   s1_x, s1_neg, s1_shr,
//   s1_over, s1_mode          registered S1 terms
//   y                         selected activation result
module activation_lane
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_MAX   = 1024
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic                         neg,
    output logic signed [DATA_WIDTH-1:0] shr,
    output logic                         over,
    input  logic signed [DATA_WIDTH-1:0] s1_x,
    input  logic                         s1_neg,
    input  logic signed [DATA_WIDTH-1:0] s1_shr,
    input  logic                         s1_over,
    input  act_mode_t                    s1_mode,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam logic signed [DATA_WIDTH-1:0] CLIP_V = DATA_WIDTH'(CLIP_MAX);

    assign neg  = x[DATA_WIDTH-1];
    // Arithmetic shift floors toward -inf, so small negatives settle at -1.
    assign shr  = x >>> LEAK_SHIFT;
    assign over = (x > CLIP_V);

    always_comb begin
        y = s1_x;
        case (s1_mode)
            ACT_IDENT: y = s1_x;
            ACT_RELU:  if (s1_neg) y = '0;
            ACT_LEAKY: if (s1_neg) y = s1_shr;
            ACT_CLIP: begin
                if (s1_neg)       y = '0;
                else if (s1_over) y = CLIP_V;
            end
            default:   y = s1_x;
        endcase
    end

endmodule

// File: rtl/activation.sv
// Multi-lane activation stage: identity / ReLU / leaky ReLU / clipped ReLU,
// selected per beat. Two registered stages with full valid/ready backpressure.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   act       activation_if slave (input and output streams)
// Optional build macro ACTIVATION_STATS_EN adds:
//   activation_stats_clr  in   clears the saturation counter (wins over increment)
//   activation_sat_count  out  saturating count of output beats with a zeroed
//                              or clipped lane
module activation
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CHANNELS   = 1,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_MAX   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    activation_if.slave        act
`ifdef ACTIVATION_STATS_EN
    ,
    input  logic               activation_stats_clr,
    output logic [STATS_W-1:0] activation_sat_count
`endif
);

    localparam int W = CHANNELS * DATA_WIDTH;

    logic            s1_valid, s2_valid;
    logic            s1_en, s2_en;
    act_mode_t       s1_mode;
    logic [W-1:0]    s1_x, s1_shr;
    logic [CHANNELS-1:0] s1_neg, s1_over;
    logic [W-1:0]    s2_y;

    logic [W-1:0]    lane_shr, lane_y;
    logic [CHANNELS-1:0] lane_neg, lane_over;

    assign s2_en = act.activation_ready_out | ~s2_valid;
    assign s1_en = s2_en | ~s1_valid;
    assign act.activation_ready_in = ~rst & s1_en;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        activation_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .CLIP_MAX   (CLIP_MAX)
        ) u_lane (
            .x       (act.activation_data_in[k*DATA_WIDTH +: DATA_WIDTH]),
            .neg     (lane_neg[k]),
            .shr     (lane_shr[k*DATA_WIDTH +: DATA_WIDTH]),
            .over    (lane_over[k]),
            .s1_x    (s1_x[k*DATA_WIDTH +: DATA_WIDTH]),
            .s1_neg  (s1_neg[k]),
            .s1_shr  (s1_shr[k*DATA_WIDTH +: DATA_WIDTH]),
            .s1_over (s1_over[k]),
            .s1_mode (s1_mode),
            .y       (lane_y[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_shr   <= '0;
            s1_neg   <= '0;
            s1_over  <= '0;
            s1_mode  <= ACT_IDENT;
        end else if (s1_en) begin
            // A bubble still loads; its payload is ignored downstream.
            s1_valid <= act.activation_valid_in;
            s1_x     <= act.activation_data_in;
            s1_shr   <= lane_shr;
            s1_neg   <= lane_neg;
            s1_over  <= lane_over;
            s1_mode  <= act.activation_mode_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            s2_y     <= lane_y;
        end
    end

    assign act.activation_valid_out = s2_valid;
    assign act.activation_data_out  = s2_y;

`ifdef ACTIVATION_STATS_EN
    // Mode is shared by all lanes of a beat, so the beat-level flag can be
    // formed from the OR of the per-lane sign / over-range terms.
    logic               s1_sat, s2_sat;
    logic [STATS_W-1:0] sat_cnt;

    assign s1_sat = (((s1_mode == ACT_RELU) || (s1_mode == ACT_CLIP)) && (|s1_neg))
                  || ((s1_mode == ACT_CLIP) && (|s1_over));

    always_ff @(posedge clk) begin
        if (rst)        s2_sat <= 1'b0;
        else if (s2_en) s2_sat <= s1_sat;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt <= '0;
        else if (activation_stats_clr)
            sat_cnt <= '0;
        else if (s2_valid && act.activation_ready_out && s2_sat && (sat_cnt != '1))
            sat_cnt <= sat_cnt + 1'b1;
    end

    assign activation_sat_count = sat_cnt;
`endif

endmodule

// File: tb/tb_activation.sv
// Directed self-checking bench for activation (DATA_WIDTH=12, CHANNELS=4,
// LEAK_SHIFT=3, CLIP_MAX=1024). Build with ACTIVATION_STATS_EN to also cover
// the saturation counter.
module tb_activation;
    import activation_pkg::*;

    localparam int DW = 12;
    localparam int CH = 4;
    localparam int W  = DW * CH;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    activation_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

`ifdef ACTIVATION_STATS_EN
    logic        stats_clr;
    logic [15:0] sat_count;
`endif

    activation #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .LEAK_SHIFT (3),
        .CLIP_MAX   (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .act (bus)
`ifdef ACTIVATION_STATS_EN
        ,
        .activation_stats_clr (stats_clr),
        .activation_sat_count (sat_count)
`endif
    );

    // Presents one beat from posedge+1 and holds it until it is accepted.
    // Returns at posedge+1 just after the accepting edge.
    task automatic send_one(input logic [W-1:0] data, input act_mode_t mode);
        bit done = 0;
        bus.activation_valid_in = 1'b1;
        bus.activation_data_in  = data;
        bus.activation_mode_in  = mode;
        for (int i = 0; i < 20 && !done; i++) begin
            #3;
            done = (bus.activation_ready_in === 1'b1);
            @(posedge clk); #1;
        end
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: ready_in never high for beat %h", data);
        end
        bus.activation_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.activation_valid_in  = 1'b0;
        bus.activation_data_in   = '0;
        bus.activation_mode_in   = ACT_IDENT;
        bus.activation_ready_out = 1'b1;
`ifdef ACTIVATION_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.activation_ready_in !== 1'b0) begin
            errors++; $display("FAIL reset_ready_in: got %b want 0", bus.activation_ready_in);
        end
        checks++;
        if (bus.activation_valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid_out: got %b want 0", bus.activation_valid_out);
        end
        checks++;
        if (bus.activation_data_out !== 48'h0) begin
            errors++; $display("FAIL reset_data_out: got %h want 0", bus.activation_data_out);
        end
`ifdef ACTIVATION_STATS_EN
        checks++;
        if (sat_count !== 16'h0) begin
            errors++; $display("FAIL reset_sat_count: got %h want 0", sat_count);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (bus.activation_ready_in !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready_in: got %b want 1", bus.activation_ready_in);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_relu();
        send_one({12'hFF8, 12'h005, 12'h800, 12'h7FF}, ACT_RELU);
        checks++;
        if (bus.activation_valid_out !== 1'b0) begin
            errors++; $display("FAIL relu_latency_early: valid_out %b want 0", bus.activation_valid_out);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.activation_valid_out !== 1'b1) begin
            errors++; $display("FAIL relu_valid: got %b want 1", bus.activation_valid_out);
        end
        checks++;
        if (bus.activation_data_out !== {12'h000, 12'h005, 12'h000, 12'h7FF}) begin
            errors++; $display("FAIL relu_data: got %h want %h", bus.activation_data_out,
                               {12'h000, 12'h005, 12'h000, 12'h7FF});
        end
    endtask

    task automatic test_leaky();
        send_one({12'hFF8, 12'hF9C, 12'hFFF, 12'h032}, ACT_LEAKY);
        @(posedge clk); #1;
        checks++;
        if (bus.activation_valid_out !== 1'b1) begin
            errors++; $display("FAIL leaky_valid: got %b want 1", bus.activation_valid_out);
        end
        checks++;
        if (bus.activation_data_out !== {12'hFFF, 12'hFF3, 12'hFFF, 12'h032}) begin
            errors++; $display("FAIL leaky_data: got %h want %h", bus.activation_data_out,
                               {12'hFFF, 12'hFF3, 12'hFFF, 12'h032});
        end
    endtask

    task automatic test_clip();
`ifdef ACTIVATION_STATS_EN
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        checks++;
        if (sat_count !== 16'h0) begin
            errors++; $display("FAIL clip_cnt_cleared: got %h want 0", sat_count);
        end
`endif
        send_one({12'h7D0, 12'h400, 12'hFFD, 12'h007}, ACT_CLIP);
        @(posedge clk); #1;
        checks++;
        if (bus.activation_valid_out !== 1'b1) begin
            errors++; $display("FAIL clip_valid: got %b want 1", bus.activation_valid_out);
        end
        checks++;
        if (bus.activation_data_out !== {12'h400, 12'h400, 12'h000, 12'h007}) begin
            errors++; $display("FAIL clip_data: got %h want %h", bus.activation_data_out,
                               {12'h400, 12'h400, 12'h000, 12'h007});
        end
        @(posedge clk); #1;
`ifdef ACTIVATION_STATS_EN
        checks++;
        if (sat_count !== 16'h1) begin
            errors++; $display("FAIL clip_sat_count: got %h want 1", sat_count);
        end
`endif
    endtask

    task automatic test_stream();
        logic [W-1:0] in_d  [8];
        act_mode_t    in_m  [8];
        logic [W-1:0] exp_d [8];
        bit           rdy_pat [4];
        int           in_idx = 0;
        int           out_idx = 0;
        int           cyc = 0;
        bit           prev_stall = 0;
        logic [W-1:0] prev_data = '0;

        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;

        in_d[0] = {12'hFF0, 12'h010, 12'h800, 12'h7FF}; in_m[0] = ACT_IDENT;
        in_d[1] = {12'hFF0, 12'h010, 12'h800, 12'h7FF}; in_m[1] = ACT_RELU;
        in_d[2] = {12'hFF0, 12'h010, 12'h800, 12'h7FF}; in_m[2] = ACT_LEAKY;
        in_d[3] = {12'hFF0, 12'h010, 12'h800, 12'h7FF}; in_m[3] = ACT_CLIP;
        in_d[4] = {12'h123, 12'hE00, 12'h001, 12'hFFF}; in_m[4] = ACT_IDENT;
        in_d[5] = {12'h123, 12'hE00, 12'h001, 12'hFFF}; in_m[5] = ACT_RELU;
        in_d[6] = {12'h123, 12'hE00, 12'h001, 12'hFFF}; in_m[6] = ACT_LEAKY;
        in_d[7] = {12'h123, 12'hE00, 12'h001, 12'hFFF}; in_m[7] = ACT_CLIP;

        exp_d[0] = {12'hFF0, 12'h010, 12'h800, 12'h7FF};
        exp_d[1] = {12'h000, 12'h010, 12'h000, 12'h7FF};
        exp_d[2] = {12'hFFE, 12'h010, 12'hF00, 12'h7FF};
        exp_d[3] = {12'h000, 12'h010, 12'h000, 12'h400};
        exp_d[4] = {12'h123, 12'hE00, 12'h001, 12'hFFF};
        exp_d[5] = {12'h123, 12'h000, 12'h001, 12'h000};
        exp_d[6] = {12'h123, 12'hFC0, 12'h001, 12'hFFF};
        exp_d[7] = {12'h123, 12'h000, 12'h001, 12'h000};

        while (out_idx < 8 && cyc < 200) begin
            bus.activation_ready_out = rdy_pat[cyc % 4];
            if (in_idx < 8) begin
                bus.activation_valid_in = 1'b1;
                bus.activation_data_in  = in_d[in_idx];
                bus.activation_mode_in  = in_m[in_idx];
            end else begin
                bus.activation_valid_in = 1'b0;
            end
            #4;
            if (prev_stall) begin
                checks++;
                if (bus.activation_valid_out !== 1'b1 || bus.activation_data_out !== prev_data) begin
                    errors++;
                    $display("FAIL stream_stall_stable: got v=%b d=%h want v=1 d=%h",
                             bus.activation_valid_out, bus.activation_data_out, prev_data);
                end
            end
            if (bus.activation_ready_in !== 1'b1) begin
                checks++;
                if (!(bus.activation_valid_out === 1'b1 && bus.activation_ready_out === 1'b0)) begin
                    errors++;
                    $display("FAIL stream_ready_in: ready_in low with valid_out=%b ready_out=%b",
                             bus.activation_valid_out, bus.activation_ready_out);
                end
            end
            if (bus.activation_valid_in && bus.activation_ready_in === 1'b1)
                in_idx++;
            if (bus.activation_valid_out === 1'b1 && bus.activation_ready_out) begin
                checks++;
                if (bus.activation_data_out !== exp_d[out_idx]) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got %h want %h", out_idx,
                             bus.activation_data_out, exp_d[out_idx]);
                end
                out_idx++;
            end
            prev_stall = (bus.activation_valid_out === 1'b1) && !bus.activation_ready_out;
            prev_data  = bus.activation_data_out;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (out_idx != 8) begin
            errors++; $display("FAIL stream_timeout: got %0d beats want 8", out_idx);
        end
        bus.activation_valid_in  = 1'b0;
        bus.activation_ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        bit stale = 0;
        bus.activation_ready_out = 1'b0;
        bus.activation_valid_in  = 1'b1;
        bus.activation_mode_in   = ACT_IDENT;
        bus.activation_data_in   = {12'h111, 12'h222, 12'h333, 12'h444};
        @(posedge clk); #1;
        bus.activation_data_in   = {12'h555, 12'h666, 12'h777, 12'h888};
        @(posedge clk); #1;
        bus.activation_valid_in  = 1'b0;
        checks++;
        if (bus.activation_valid_out !== 1'b1) begin
            errors++; $display("FAIL midrst_inflight: valid_out %b want 1", bus.activation_valid_out);
        end
        rst = 1'b1;
        #3;
        checks++;
        if (bus.activation_ready_in !== 1'b0) begin
            errors++; $display("FAIL midrst_ready_in: got %b want 0", bus.activation_ready_in);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.activation_valid_out !== 1'b0) begin
            errors++; $display("FAIL midrst_valid_out: got %b want 0", bus.activation_valid_out);
        end
        checks++;
        if (bus.activation_data_out !== 48'h0) begin
            errors++; $display("FAIL midrst_data_out: got %h want 0", bus.activation_data_out);
        end
        rst = 1'b0;
        bus.activation_ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            if (bus.activation_valid_out !== 1'b0) stale = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (stale) begin
            errors++; $display("FAIL midrst_stale_beat: valid_out seen 1 want 0");
        end
    endtask

`ifdef ACTIVATION_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        bus.activation_ready_out = 1'b1;
        bus.activation_valid_in  = 1'b1;
        bus.activation_mode_in   = ACT_RELU;
        bus.activation_data_in   = {4{12'hFFF}};
        repeat (65535) @(posedge clk);
        #1;
        bus.activation_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++; $display("FAIL stats_reach_max: got %h want FFFF", sat_count);
        end
        send_one({4{12'hFFF}}, ACT_CLIP);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++; $display("FAIL stats_saturate: got %h want FFFF", sat_count);
        end
        bus.activation_ready_out = 1'b0;
        send_one({4{12'hFFF}}, ACT_RELU);
        @(posedge clk); #1;
        checks++;
        if (bus.activation_valid_out !== 1'b1) begin
            errors++; $display("FAIL stats_beat_waiting: valid_out %b want 1", bus.activation_valid_out);
        end
        bus.activation_ready_out = 1'b1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        checks++;
        if (sat_count !== 16'h0) begin
            errors++; $display("FAIL stats_clr_priority: got %h want 0", sat_count);
        end
        checks++;
        if (bus.activation_valid_out !== 1'b0) begin
            errors++; $display("FAIL stats_beat_drained: valid_out %b want 0", bus.activation_valid_out);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_relu();
        test_leaky();
        test_clip();
        test_stream();
        test_reset_midstream();
`ifdef ACTIVATION_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
